// File: rtl/sm2201_cycle_arbiter.sv
// Round-robin arbiter and cycle sequencer sharing micro_program_automate between host (0) and poller (1).
// Define SM2201_ARB_TIMEOUT_EN to add the rdy watchdog and the sticky err flag.
module sm2201_cycle_arbiter #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_req,
  input  logic [1:0] host_a,
  input  logic       host_w,
  output logic       host_ack,
  input  logic       poll_req,
  input  logic [1:0] poll_a,
  input  logic       poll_w,
  output logic       poll_ack,
  input  logic       ie_cfg,
  output logic [1:0] a,
  output logic       w,
  output logic       sel,
  output logic       ie,
  input  logic       rdy,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  // state   | meaning
  // IDLE    | no cycle owned, arbitrating pending requests
  // SETUP   | a/w latched and stable, sel low, counting SETUP_CYCLES
  // ACTIVE  | sel high, waiting for rdy
  // RELEASE | sel low, waiting for rdy to return low
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACTIVE, ST_RELEASE} state_t;

  state_t     state_q;
  logic [1:0] a_q;
  logic       w_q;
  logic       sel_q;
  logic       ie_q;
  logic       host_ack_q;
  logic       poll_ack_q;
  logic       busy_q;
  logic       ptr_q;
  logic       owner_q;
  logic [3:0] setup_cnt_q;
  logic       win_poll;
  logic       to_expired;

  // ptr_q = 1 gives the poller priority when both requesters are pending
  assign win_poll = poll_req & (~host_req | ptr_q);

`ifdef SM2201_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q;
  logic        err_q;
  logic        err_set;

  assign to_expired = (to_cnt_q == 16'd0);
  assign err_set    = to_expired &
                      (((state_q == ST_ACTIVE) & ~rdy) | ((state_q == ST_RELEASE) & rdy));

  // reloads on every entry into ACTIVE and RELEASE, so each phase gets its own full budget
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == ST_RELEASE) ||
          ((state_q == ST_ACTIVE) && !rdy && !to_expired)) begin
        to_cnt_q <= to_cnt_q - 16'd1;
      end else begin
        to_cnt_q <= TO_LOAD;
      end
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic [16:0] unused_cfg;

  assign unused_cfg = {err_clr, 16'(TIMEOUT_CYCLES)};
  assign to_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= 2'd0;
      w_q         <= 1'b0;
      sel_q       <= 1'b0;
      ie_q        <= 1'b0;
      host_ack_q  <= 1'b0;
      poll_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      setup_cnt_q <= 4'd0;
    end else begin
      ie_q       <= ie_cfg;
      host_ack_q <= 1'b0;
      poll_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (host_req | poll_req) begin
            a_q         <= win_poll ? poll_a : host_a;
            w_q         <= win_poll ? poll_w : host_w;
            owner_q     <= win_poll;
            ptr_q       <= ~win_poll;
            setup_cnt_q <= 4'(SETUP_CYCLES);
            busy_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          setup_cnt_q <= setup_cnt_q - 4'd1;
          if (setup_cnt_q == 4'd1) begin
            sel_q   <= 1'b1;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (rdy | to_expired) begin
            sel_q      <= 1'b0;
            host_ack_q <= ~owner_q;
            poll_ack_q <= owner_q;
            state_q    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!rdy || to_expired) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          sel_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a        = a_q;
  assign w        = w_q;
  assign sel      = sel_q;
  assign ie       = ie_q;
  assign host_ack = host_ack_q;
  assign poll_ack = poll_ack_q;
  assign busy     = busy_q;

endmodule

// File: doc/sm2201_cycle_arbiter.md
# sm2201_cycle_arbiter

Two-requester arbiter and cycle sequencer in front of `micro_program_automate` on the SM2201 ISA–CAMAC interface board. It shares the automate between the ISA host register path (requester 0) and the LAM/status poller (requester 1). For each granted cycle it drives `a`, `w`, `sel` and `ie`, waits for `rdy`, returns a one-cycle acknowledge to the winner, and guards against a hung automate.

## Interface
Parameters:
- `SETUP_CYCLES`, default 2: clocks that `a`/`w` are stable before `sel` asserts; legal range 1..15.
- `TIMEOUT_CYCLES`, default 1023: maximum clocks spent waiting for `rdy`; legal range 1..65535.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `host_req`  in  1  host cycle request; level, held until `host_ack`.
- `host_a`  in  2  host register address.
- `host_w`  in  1  host direction; 1 = write.
- `host_ack`  out  1  one-clock pulse when the host cycle completes.
- `poll_req`  in  1  poller request; level, held until `poll_ack`.
- `poll_a`  in  2  poller register address.
- `poll_w`  in  1  poller direction; 1 = write.
- `poll_ack`  out  1  one-clock pulse when the poller cycle completes.
- `ie_cfg`  in  1  interrupt-enable setting from the control register.
- `a`  out  2  automate address.
- `w`  out  1  automate direction.
- `sel`  out  1  automate select.
- `ie`  out  1  automate interrupt enable.
- `rdy`  in  1  automate done; must be synchronous to `clk`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- States: IDLE → SETUP → ACTIVE → RELEASE → IDLE.
- **IDLE:** if any request is pending, latch the winner's address and direction into `a`/`w`, record the owner, load the setup counter with `SETUP_CYCLES`, and go to SETUP.
- **SETUP:** `sel` is 0 and the counter decrements. When it reaches 0, assert `sel` and go to ACTIVE.
- **ACTIVE:** `sel` is 1. When `rdy` is 1, deassert `sel`, pulse the owner's ack, and go to RELEASE.
- **RELEASE:** `sel` is 0. Wait for `rdy` to be 0, then go to IDLE. A new grant is therefore never issued while `rdy` is still high.
- Arbitration is round-robin. The priority pointer starts at host and flips to the non-winner after each grant. A lone requester always wins.
- Simultaneous requests: the pointer decides; the other requester waits exactly one cycle.
- A request that drops before grant is ignored; no ack is issued. Request changes after grant are ignored because `a`/`w` are latched.
- `ie` is a registered copy of `ie_cfg`, updated every clock regardless of state.
- `err_clr` has priority over a simultaneous timeout set.

## Timing
- Reset values: `a`=0, `w`=0, `sel`=0, `ie`=0, `host_ack`=0, `poll_ack`=0, `busy`=0, `err`=0, state IDLE, pointer = host.
- Reset asserted mid-cycle forces all of the above immediately (asynchronously). No ack is produced for the aborted cycle.
- Request-to-`sel` latency: `SETUP_CYCLES`+1 clocks (one IDLE clock plus the setup count).
- `rdy` high in ACTIVE sets `sel`=0 and the ack =1 on the next clock edge. The ack lasts exactly one clock.
- Minimum back-to-back spacing: RELEASE lasts at least one clock. The next `sel` follows ack by at least `SETUP_CYCLES`+2 clocks.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `SM2201_ARB_TIMEOUT_EN`.
- **Defined:** a 16-bit counter runs in ACTIVE and in RELEASE.
  - In ACTIVE: reaching `TIMEOUT_CYCLES` without `rdy` deasserts `sel`, sets `err`=1, pulses the owner's ack (the cycle is abandoned), and goes to RELEASE.
  - In RELEASE: reaching `TIMEOUT_CYCLES` with `rdy` still high sets `err` and forces IDLE.
- **Undefined:** there is no counter, the block waits indefinitely, and `err` is tied to 0.

## Test plan
- Reset, then host request with `host_a`=2, `host_w`=1; `rdy` rises 5 clocks after `sel` → `a`=2, `w`=1; `sel` rises 3 clocks after the request (default setup); `host_ack` is a single pulse 1 clock after `rdy`; `busy` falls after `rdy` drops.
- `host_req` and `poll_req` asserted on the same clock, both held → cycles granted host, poll, host, poll; each ack matches its owner's latched `a`.
- Poll request only, 4 consecutive cycles → every cycle is granted to poll with no idle penalty beyond RELEASE plus SETUP.
- `rdy` held high after ack for 10 clocks while host requests again → no `sel` until `rdy` is 0; then `sel` after SETUP.
- With `SM2201_ARB_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=20, `rdy` never asserted → `sel` drops after 20 clocks in ACTIVE, `err`=1, ack pulses; `err_clr` returns `err` to 0. Without the macro, `sel` stays high for 1000 clocks.
- Assert `reset` in the middle of ACTIVE → `sel`, `busy` and `a` are 0 immediately; after release, a fresh host request is granted first.
